// File: rtl/rotate_align_100.sv
// rotate_align_100: receive-side alignment engine for 100-bit words.
// It takes a word that was rotated by an unknown amount and rotates it back
// one bit per cycle until SYNC_PAT sits in the top SYNC_W bits. It then
// returns the aligned word and the rotation count.
// Optional feature macro: ROT_ALIGN_BIDIR_EN. When it is defined, the block
// searches with a right-rotated copy and a left-rotated copy in parallel.
//
// Handshake: a word moves on an input edge where in_valid && in_ready. A
// result moves on an output edge where out_valid && out_ready. in_ready and
// out_valid are pure state decodes. Once out_valid is set, the outputs stay
// stable until the result is taken.
module rotate_align_100 #(
    parameter int                SYNC_W   = 8,
    parameter logic [SYNC_W-1:0] SYNC_PAT = 8'hA5
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [99:0] data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [99:0] out_data,
    output logic [6:0]  out_rot,
    output logic        out_dir,
    output logic        out_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

`ifdef ROT_ALIGN_BIDIR_EN
    localparam logic [6:0] LAST_CNT = 7'd50;
`else
    localparam logic [6:0] LAST_CNT = 7'd99;
`endif

    state_t      state;
    state_t      state_next;
    logic [99:0] work_r;
    logic [6:0]  cnt;
    logic        hit_r;
    logic        hit_l;

    assign hit_r = (work_r[99 -: SYNC_W] == SYNC_PAT);

`ifdef ROT_ALIGN_BIDIR_EN
    logic [99:0] work_l;
    logic        dir_q;
    assign hit_l   = (work_l[99 -: SYNC_W] == SYNC_PAT);
    assign out_dir = dir_q;
`else
    assign hit_l   = 1'b0;
    assign out_dir = 1'b0;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode. The search ends on the first hit or after the last count.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = SEARCH;
            SEARCH:  if (hit_r || hit_l || (cnt == LAST_CNT)) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Working copies, rotation counter and registered result.
    // The right copy takes priority over the left copy when both hit at the same count.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            work_r   <= '0;
            cnt      <= '0;
            out_data <= '0;
            out_rot  <= '0;
            out_err  <= 1'b0;
`ifdef ROT_ALIGN_BIDIR_EN
            work_l   <= '0;
            dir_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work_r <= data;
                        cnt    <= '0;
`ifdef ROT_ALIGN_BIDIR_EN
                        work_l <= data;
`endif
                    end
                end
                SEARCH: begin
                    if (hit_r) begin
                        out_data <= work_r;
                        out_rot  <= cnt;
                        out_err  <= 1'b0;
`ifdef ROT_ALIGN_BIDIR_EN
                        dir_q    <= 1'b0;
                    end else if (hit_l) begin
                        out_data <= work_l;
                        out_rot  <= cnt;
                        out_err  <= 1'b0;
                        dir_q    <= 1'b1;
`endif
                    end else if (cnt == LAST_CNT) begin
                        out_data <= work_r;
                        out_rot  <= cnt;
                        out_err  <= 1'b1;
`ifdef ROT_ALIGN_BIDIR_EN
                        dir_q    <= 1'b0;
`endif
                    end else begin
                        work_r <= {work_r[0], work_r[99:1]};
                        cnt    <= cnt + 7'd1;
`ifdef ROT_ALIGN_BIDIR_EN
                        work_l <= {work_l[98:0], work_l[99]};
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rotate_align_100.sv
// Directed testbench for rotate_align_100. It applies a table of vectors with
// hand-derived results, then runs separate sequences for backpressure and
// for reset in the middle of a search.
module tb_rotate_align_100;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [99:0] data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [99:0] out_data;
    logic [6:0]  out_rot;
    logic        out_dir;
    logic        out_err;

    int checks = 0;
    int errors = 0;

    rotate_align_100 dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data      (data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_rot   (out_rot),
        .out_dir   (out_dir),
        .out_err   (out_err)
    );

    // clock / reset
    always #5 clk = ~clk;

    typedef struct {
        logic [99:0] din;
        logic [99:0] exp_data;
        logic [6:0]  exp_rot;
        logic        exp_err;
        logic        exp_dir;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];

    function automatic logic [99:0] rotl(input logic [99:0] x, input int n);
        logic [99:0] r;
        r = x;
        for (int i = 0; i < n; i++) r = {r[98:0], r[99]};
        return r;
    endfunction

    task automatic check(input string name, input logic [99:0] act, input logic [99:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Offer one word, return the cycles from the accept edge until out_valid is seen.
    task automatic send_and_wait(input logic [99:0] d, output int lat);
        @(negedge clk);
        check("in_ready_before_accept", 100'(in_ready), 100'd1);
        data     = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 200);
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_after_take", 100'(out_valid), 100'd0);
        check("in_ready_after_take", 100'(in_ready), 100'd1);
    endtask

    initial begin
        logic [99:0] orig;
        logic [99:0] orig2;
        logic [99:0] hold_data;
        logic [6:0]  hold_rot;
        logic        seen;
        int          lat;

        orig  = {8'hA5, 92'h0};
        orig2 = {8'hA5, 92'h123};

        vecs[0].din = {8'hA5, 28'($urandom), 32'($urandom), 32'($urandom)};
        vecs[0].exp_data = vecs[0].din;
        vecs[0].exp_rot = 7'd0; vecs[0].exp_err = 1'b0; vecs[0].exp_dir = 1'b0; vecs[0].exp_lat = 1;

        vecs[1].din = rotl(orig2, 3);
        vecs[1].exp_data = orig2;
        vecs[1].exp_rot = 7'd3; vecs[1].exp_err = 1'b0; vecs[1].exp_dir = 1'b0; vecs[1].exp_lat = 4;

        vecs[2].din = '0;
        vecs[2].exp_data = '0; vecs[2].exp_err = 1'b1; vecs[2].exp_dir = 1'b0;
        vecs[3].din = '1;
        vecs[3].exp_data = '1; vecs[3].exp_err = 1'b1; vecs[3].exp_dir = 1'b0;
`ifdef ROT_ALIGN_BIDIR_EN
        vecs[2].exp_rot = 7'd50; vecs[2].exp_lat = 51;
        vecs[3].exp_rot = 7'd50; vecs[3].exp_lat = 51;
`else
        vecs[2].exp_rot = 7'd99; vecs[2].exp_lat = 100;
        vecs[3].exp_rot = 7'd99; vecs[3].exp_lat = 100;
`endif

        vecs[4].din = rotl(orig, 57);
        vecs[4].exp_data = orig; vecs[4].exp_err = 1'b0;
        vecs[5].din = rotl(orig, 99);
        vecs[5].exp_data = orig; vecs[5].exp_err = 1'b0;
        vecs[6].din = rotl(orig, 98);
        vecs[6].exp_data = orig; vecs[6].exp_err = 1'b0;
`ifdef ROT_ALIGN_BIDIR_EN
        vecs[4].exp_rot = 7'd43; vecs[4].exp_dir = 1'b1; vecs[4].exp_lat = 44;
        vecs[5].exp_rot = 7'd1;  vecs[5].exp_dir = 1'b1; vecs[5].exp_lat = 2;
        vecs[6].exp_rot = 7'd2;  vecs[6].exp_dir = 1'b1; vecs[6].exp_lat = 3;
`else
        vecs[4].exp_rot = 7'd57; vecs[4].exp_dir = 1'b0; vecs[4].exp_lat = 58;
        vecs[5].exp_rot = 7'd99; vecs[5].exp_dir = 1'b0; vecs[5].exp_lat = 100;
        vecs[6].exp_rot = 7'd98; vecs[6].exp_dir = 1'b0; vecs[6].exp_lat = 99;
`endif

        // reset state
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        check("rst_in_ready", 100'(in_ready), 100'd1);
        check("rst_out_valid", 100'(out_valid), 100'd0);
        check("rst_out_err", 100'(out_err), 100'd0);
        check("rst_out_rot", 100'(out_rot), 100'd0);
        check("rst_out_dir", 100'(out_dir), 100'd0);
        check("rst_out_data", out_data, 100'd0);

        // table-driven vectors
        for (int i = 0; i < 7; i++) begin
            send_and_wait(vecs[i].din, lat);
            check($sformatf("v%0d_latency", i), 100'(lat), 100'(vecs[i].exp_lat));
            check($sformatf("v%0d_out_valid", i), 100'(out_valid), 100'd1);
            check($sformatf("v%0d_out_rot", i), 100'(out_rot), 100'(vecs[i].exp_rot));
            check($sformatf("v%0d_out_err", i), 100'(out_err), 100'(vecs[i].exp_err));
            check($sformatf("v%0d_out_dir", i), 100'(out_dir), 100'(vecs[i].exp_dir));
            check($sformatf("v%0d_out_data", i), out_data, vecs[i].exp_data);
            take_result();
        end

        // backpressure: result held with in_valid high, second word accepted one cycle after the handshake
        send_and_wait(rotl(orig2, 5), lat);
        check("bp_latency", 100'(lat), 100'd6);
        hold_data = out_data;
        hold_rot  = out_rot;
        check("bp_data", hold_data, orig2);
        check("bp_rot", 100'(hold_rot), 100'd5);
        data     = {8'hA5, 92'h5};
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", 100'(out_valid), 100'd1);
            check("bp_hold_in_ready", 100'(in_ready), 100'd0);
            check("bp_hold_data", out_data, orig2);
            check("bp_hold_rot", 100'(out_rot), 100'd5);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_handshake_in_ready", 100'(in_ready), 100'd1);
        check("bp_handshake_valid", 100'(out_valid), 100'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_second_accepted", 100'(in_ready), 100'd0);
        @(posedge clk);
        #1;
        check("bp_second_valid", 100'(out_valid), 100'd1);
        check("bp_second_data", out_data, {8'hA5, 92'h5});
        check("bp_second_rot", 100'(out_rot), 100'd0);
        take_result();

        // reset mid-search: the search would need 40 rotations, reset lands at E+20
        @(negedge clk);
        data     = rotl(orig, 40);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        check("mid_search_busy", 100'(in_ready), 100'd0);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        check("mr_in_ready", 100'(in_ready), 100'd1);
        check("mr_out_valid", 100'(out_valid), 100'd0);
        check("mr_out_err", 100'(out_err), 100'd0);
        check("mr_out_rot", 100'(out_rot), 100'd0);
        check("mr_out_dir", 100'(out_dir), 100'd0);
        check("mr_out_data", out_data, 100'd0);
        seen = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("mr_no_stale_result", 100'(seen), 100'd0);
        check("mr_idle_after", 100'(in_ready), 100'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
